// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, FSM state type and pattern mixing for the regfile BIST
package regfile_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int ERR_W    = 8;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      INV_WRITE,
      INV_READ,
      DONE
   } bist_state_t;

   // Address-dependent term XORed into the seed so every register holds a distinct word.
   function automatic logic [DATA_W-1:0] bist_mix(input logic [ADDR_W-1:0] i);
      return {i[1:0], {6{i}}};
   endfunction

endpackage

// File: rtl/regfile_bist_pattern.sv
// rtl/regfile_bist_pattern.sv - combinational data pattern for one register index
// check=1 gives the expected read value (register 0 forced to 0 when ZERO_REG), check=0 the write data.
module regfile_bist_pattern
   import regfile_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED     = 32'hA5A5_5A5A,
   parameter bit                ZERO_REG = 1'b1
) (
   input  logic [ADDR_W-1:0] idx,
   input  logic              invert,
   input  logic              check,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] base;

   always_comb begin
      base = SEED ^ bist_mix(idx);
      if (invert) begin
         base = ~base;
      end
      if (check && ZERO_REG && (idx == '0)) begin
         data = '0;
      end else begin
         data = base;
      end
   end

endmodule

// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - write/read-back self-test sequencer for the 32x32 register file
// Optional inverse-polarity second sweep enabled by defining REGFILE_BIST_INV_PASS_EN.
module regfile_bist
   import regfile_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED     = 32'hA5A5_5A5A,
   parameter bit                ZERO_REG = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic [ADDR_W-1:0] FailAddr,
   output logic [ERR_W-1:0]  ErrCount,
   output logic [DATA_W-1:0] WriteData,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] ReadRegister1,
   output logic [ADDR_W-1:0] ReadRegister2,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   bist_state_t       state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_inc;
   logic [ADDR_W-1:0] wr_idx;
   logic              wr_inv;
   logic [DATA_W-1:0] wr_pattern;
   logic              reading;
   logic              rd_inv;
   logic [DATA_W-1:0] exp1;
   logic [DATA_W-1:0] exp2;
   logic              mis1;
   logic              mis2;
   logic [ERR_W:0]    err_sum;
   logic [ERR_W-1:0]  err_next;
   logic              more_pass;

   // Write data is registered, so it is computed for the index of the coming cycle.
   always_comb begin
      idx_inc   = idx + 1'b1;
      wr_idx    = ((state == WRITE) || (state == INV_WRITE)) ? idx_inc : '0;
      wr_inv    = (state == READ) || (state == INV_WRITE);
      reading   = (state == READ) || (state == INV_READ);
      rd_inv    = (state == INV_READ);
`ifdef REGFILE_BIST_INV_PASS_EN
      more_pass = (state == READ);
`else
      more_pass = 1'b0;
`endif
   end

   regfile_bist_pattern #(.SEED(SEED), .ZERO_REG(ZERO_REG)) u_wr_pat (
      .idx    (wr_idx),
      .invert (wr_inv),
      .check  (1'b0),
      .data   (wr_pattern)
   );

   regfile_bist_pattern #(.SEED(SEED), .ZERO_REG(ZERO_REG)) u_exp1 (
      .idx    (idx),
      .invert (rd_inv),
      .check  (1'b1),
      .data   (exp1)
   );

   regfile_bist_pattern #(.SEED(SEED), .ZERO_REG(ZERO_REG)) u_exp2 (
      .idx    (~idx),
      .invert (rd_inv),
      .check  (1'b1),
      .data   (exp2)
   );

   always_comb begin
      mis1     = reading && (ReadData1 != exp1);
      mis2     = reading && (ReadData2 != exp2);
      err_sum  = {1'b0, ErrCount} + {{ERR_W{1'b0}}, mis1} + {{ERR_W{1'b0}}, mis2};
      err_next = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         idx           <= '0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         Pass          <= 1'b0;
         FailAddr      <= '0;
         ErrCount      <= '0;
         WriteData     <= '0;
         WriteRegister <= '0;
         RegWrite      <= 1'b0;
         ReadRegister1 <= '0;
         ReadRegister2 <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state         <= WRITE;
                  idx           <= '0;
                  Busy          <= 1'b1;
                  Done          <= 1'b0;
                  Pass          <= 1'b0;
                  FailAddr      <= '0;
                  ErrCount      <= '0;
                  RegWrite      <= 1'b1;
                  WriteRegister <= '0;
                  WriteData     <= wr_pattern;
               end
            end
            WRITE, INV_WRITE: begin
               idx <= idx_inc;
               if (idx == LAST) begin
                  state         <= (state == WRITE) ? READ : INV_READ;
                  RegWrite      <= 1'b0;
                  WriteRegister <= '0;
                  WriteData     <= '0;
                  ReadRegister1 <= '0;
                  ReadRegister2 <= LAST;
               end else begin
                  WriteRegister <= idx_inc;
                  WriteData     <= wr_pattern;
               end
            end
            READ, INV_READ: begin
               idx      <= idx_inc;
               ErrCount <= err_next;
               // A zero count means nothing has failed yet in this run.
               if ((ErrCount == '0) && (mis1 || mis2)) begin
                  FailAddr <= mis1 ? idx : ~idx;
               end
               if (idx == LAST) begin
                  ReadRegister1 <= '0;
                  ReadRegister2 <= '0;
                  if (more_pass) begin
                     state         <= INV_WRITE;
                     RegWrite      <= 1'b1;
                     WriteRegister <= '0;
                     WriteData     <= wr_pattern;
                  end else begin
                     state <= DONE;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                     Pass  <= (err_next == '0);
                  end
               end else begin
                  ReadRegister1 <= idx_inc;
                  ReadRegister2 <= ~idx_inc;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - self-checking bench for regfile_bist with a faultable register file model
module tb_regfile_bist;

   localparam logic [31:0] SEED = 32'hA5A5_5A5A;
`ifdef REGFILE_BIST_INV_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int DONE_LAT = 1 + 64 * NPASS;
   localparam logic [7:0] ERR42 = 8'(64 * NPASS);
   localparam logic [7:0] ERR_SA1 = (NPASS == 2) ? 8'd2 : 8'd0;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic        Busy, Done, Pass, RegWrite;
   logic [4:0]  FailAddr, WriteRegister, ReadRegister1, ReadRegister2;
   logic [7:0]  ErrCount;
   logic [31:0] WriteData, ReadData1, ReadData2;

   logic [31:0] mem [32];
   int          fault_mode;
   int          fault_reg;
   int          fault_bit;
   logic        fault_val;
   int          checks = 0;
   int          failures = 0;

   regfile_bist dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Start         (Start),
      .Busy          (Busy),
      .Done          (Done),
      .Pass          (Pass),
      .FailAddr      (FailAddr),
      .ErrCount      (ErrCount),
      .WriteData     (WriteData),
      .WriteRegister (WriteRegister),
      .RegWrite      (RegWrite),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (RegWrite) mem[WriteRegister] <= WriteData;
   end

   // Register file read: reg 0 hardwired, mode 1 = one stuck bit, mode 2 = always returns 42.
   function automatic logic [31:0] rf_read(input logic [4:0] a, input logic [31:0] v,
                                           input int mode, input int fr, input int fb, input logic fv);
      logic [31:0] r;
      logic [4:0]  fa;
      fa = fr[4:0];
      r = (a == 5'd0) ? 32'h0 : v;
      if (mode == 2) r = 32'd42;
      else if (mode == 1 && a == fa) r[fb] = fv;
      return r;
   endfunction

   assign ReadData1 = rf_read(ReadRegister1, mem[ReadRegister1], fault_mode, fault_reg, fault_bit, fault_val);
   assign ReadData2 = rf_read(ReadRegister2, mem[ReadRegister2], fault_mode, fault_reg, fault_bit, fault_val);

   function automatic logic [31:0] pat(input int i);
      logic [4:0] a;
      a = i[4:0];
      return SEED ^ {a[1:0], {6{a}}};
   endfunction

   // Enumerates every port read of the run in time order, port 1 before port 2.
   task automatic model(input int mode, input int fr, input int fb, input logic fv,
                        output int errs, output int faddr);
      logic [31:0] stored, expv, got;
      int a;
      bit seen;
      errs = 0; faddr = 0; seen = 0;
      for (int p = 0; p < NPASS; p++)
         for (int i = 0; i < 32; i++)
            for (int port = 0; port < 2; port++) begin
               a = (port == 0) ? i : 31 - i;
               stored = (p == 1) ? ~pat(a) : pat(a);
               expv = (a == 0) ? 32'h0 : stored;
               got = rf_read(a[4:0], stored, mode, fr, fb, fv);
               if (got != expv) begin
                  if (!seen) faddr = a;
                  seen = 1;
                  errs++;
               end
            end
      if (errs > 255) errs = 255;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called #1 after a posedge; returns cycles from Start to Done (-1 on timeout, -2 if reset).
   task automatic run(input int repulse_at, input int reset_at, output int lat,
                      output logic rpass, output logic [4:0] rfa, output logic [7:0] rerr);
      lat = -1;
      Start = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         @(posedge Clk); #1;
         if (c == 1) begin
            Start = 1'b0;
            chk("busy_after_start", 64'(Busy), 64'(1));
            chk("done_cleared", 64'(Done), 64'(0));
            chk("err_cleared", 64'(ErrCount), 64'(0));
         end
         if (c == repulse_at) Start = 1'b1;
         if (repulse_at > 0 && c == repulse_at + 1) Start = 1'b0;
         if (reset_at > 0 && c == reset_at) Reset = 1'b1;
         if (reset_at > 0 && c == reset_at + 1) begin
            Reset = 1'b0;
            chk("rst_regwrite", 64'(RegWrite), 64'(0));
            chk("rst_busy", 64'(Busy), 64'(0));
            chk("rst_done", 64'(Done), 64'(0));
            chk("rst_errcount", 64'(ErrCount), 64'(0));
            lat = -2;
            break;
         end
         if (Done) begin
            lat = c;
            break;
         end
      end
      rpass = Pass; rfa = FailAddr; rerr = ErrCount;
   endtask

   typedef struct {
      int         mode;
      int         freg;
      int         fbit;
      logic       fval;
      int         repulse;
      logic       exp_pass;
      logic [4:0] exp_fa;
      logic [7:0] exp_err;
   } vec_t;

   initial begin
      vec_t       vecs[6];
      int         lat, errs, faddr;
      logic       rpass;
      logic [4:0] rfa;
      logic [7:0] rerr;

      vecs[0] = '{0, 0, 0, 1'b0, 0, 1'b1, 5'd0, 8'd0};
      vecs[1] = '{1, 5, 3, 1'b0, 0, 1'b0, 5'd5, 8'd2};
      vecs[2] = '{2, 0, 0, 1'b0, 0, 1'b0, 5'd0, ERR42};
      vecs[3] = '{0, 0, 0, 1'b0, 20, 1'b1, 5'd0, 8'd0};
      vecs[4] = '{1, 5, 3, 1'b1, 0, (ERR_SA1 == 0), (ERR_SA1 == 0) ? 5'd0 : 5'd5, ERR_SA1};
      vecs[5] = '{2, 0, 0, 1'b0, 20, 1'b0, 5'd0, ERR42};

      Reset = 1'b1; Start = 1'b0;
      fault_mode = 0; fault_reg = 0; fault_bit = 0; fault_val = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_busy", 64'(Busy), 64'(0));
      chk("reset_done", 64'(Done), 64'(0));
      chk("reset_pass", 64'(Pass), 64'(0));
      chk("reset_failaddr", 64'(FailAddr), 64'(0));
      chk("reset_errcount", 64'(ErrCount), 64'(0));
      chk("reset_regwrite", 64'(RegWrite), 64'(0));
      chk("reset_wdata", 64'(WriteData), 64'(0));
      chk("reset_rr", 64'({WriteRegister, ReadRegister1, ReadRegister2}), 64'(0));
      Reset = 1'b0;
      @(posedge Clk); #1;

      for (int v = 0; v < 6; v++) begin
         fault_mode = vecs[v].mode; fault_reg = vecs[v].freg;
         fault_bit = vecs[v].fbit; fault_val = vecs[v].fval;
         run(vecs[v].repulse, 0, lat, rpass, rfa, rerr);
         chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(DONE_LAT));
         chk($sformatf("vec%0d_pass", v), 64'(rpass), 64'(vecs[v].exp_pass));
         chk($sformatf("vec%0d_failaddr", v), 64'(rfa), 64'(vecs[v].exp_fa));
         chk($sformatf("vec%0d_errcount", v), 64'(rerr), 64'(vecs[v].exp_err));
      end

      repeat (5) @(posedge Clk);
      #1;
      chk("done_held", 64'(Done), 64'(1));
      chk("done_busy_low", 64'(Busy), 64'(0));
      chk("done_regwrite_low", 64'(RegWrite), 64'(0));

      for (int r = 0; r < 20; r++) begin
         fault_mode = ($urandom_range(0, 4) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 0 : 1);
         fault_reg = $urandom_range(0, 31);
         fault_bit = $urandom_range(0, 31);
         fault_val = 1'($urandom_range(0, 1));
         model(fault_mode, fault_reg, fault_bit, fault_val, errs, faddr);
         run(0, 0, lat, rpass, rfa, rerr);
         chk($sformatf("rnd%0d_latency", r), 64'(lat), 64'(DONE_LAT));
         chk($sformatf("rnd%0d_pass", r), 64'(rpass), 64'(errs == 0));
         chk($sformatf("rnd%0d_failaddr", r), 64'(rfa), 64'(faddr));
         chk($sformatf("rnd%0d_errcount", r), 64'(rerr), 64'(errs));
      end

      fault_mode = 0;
      run(0, 10, lat, rpass, rfa, rerr);
      fault_mode = 2;
      run(0, 40, lat, rpass, rfa, rerr);
      chk("reset_run_aborted", 64'(lat), 64'(-2));
      @(posedge Clk); #1;
      chk("reset_idle_busy", 64'(Busy), 64'(0));
      fault_mode = 0;
      run(0, 0, lat, rpass, rfa, rerr);
      chk("post_reset_latency", 64'(lat), 64'(DONE_LAT));
      chk("post_reset_pass", 64'(rpass), 64'(1));
      chk("post_reset_errcount", 64'(rerr), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
